// File: rtl/vga_timing_generator_if.sv
// Raster timing bundle from vga_timing_generator to the colour driver and frame consumers.
interface vga_timing_if;
  logic [9:0] current_row;
  logic [9:0] current_line;
  logic       enable;
  logic       hsync;
  logic       vsync;
  logic       pixel_tick;
  logic       frame_start;

  modport master (
    output current_row, current_line, enable, hsync, vsync, pixel_tick, frame_start
  );
  modport slave (
    input  current_row, current_line, enable, hsync, vsync, pixel_tick, frame_start
  );
endinterface

// File: rtl/vga_timing_generator.sv
// 640x480@60 raster timing: prescaled pixel tick, x/y counters, enable, active-low syncs, frame_start.
// Optional VGA_SYNC_DELAY_EN: one extra clk_in register on hsync/vsync to line up with a registered colour path.
module vga_timing_generator #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic         clk_in,
  input  logic         reset,
  vga_timing_if.master vid
);
  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [9:0]       h_q, v_q, h_nxt, v_nxt;
  logic             en_q, hs_q, vs_q, pt_q, fs_q;
  logic             en_nxt, hs_nxt, vs_nxt, fs_nxt;

  assign tick = (div_cnt == DIV_LAST);

  // Decodes are taken from the next position so every output register
  // describes the same pixel as the counters after the tick edge.
  always_comb begin
    h_nxt = (h_q == H_LAST) ? 10'd0 : h_q + 10'd1;
    v_nxt = v_q;
    if (h_q == H_LAST)
      v_nxt = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
    en_nxt = (h_nxt < H_ACT) && (v_nxt < V_ACT);
    hs_nxt = !((h_nxt >= HS_BEG) && (h_nxt < HS_END));
    vs_nxt = !((v_nxt >= VS_BEG) && (v_nxt < VS_END));
    fs_nxt = (h_nxt == 10'd0) && (v_nxt == 10'd0);
  end

  // Reset parks the raster on its last position so the first tick lands on (0,0).
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      h_q     <= H_LAST;
      v_q     <= V_LAST;
      en_q    <= 1'b0;
      hs_q    <= 1'b1;
      vs_q    <= 1'b1;
      pt_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + 1'b1;
      pt_q    <= tick;
      fs_q    <= tick && fs_nxt;
      if (tick) begin
        h_q  <= h_nxt;
        v_q  <= v_nxt;
        en_q <= en_nxt;
        hs_q <= hs_nxt;
        vs_q <= vs_nxt;
      end
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_d, vs_d;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      hs_d <= 1'b1;
      vs_d <= 1'b1;
    end else begin
      hs_d <= hs_q;
      vs_d <= vs_q;
    end
  end

  assign vid.hsync = hs_d;
  assign vid.vsync = vs_d;
`else
  assign vid.hsync = hs_q;
  assign vid.vsync = vs_q;
`endif

  assign vid.current_row  = h_q;
  assign vid.current_line = v_q;
  assign vid.enable       = en_q;
  assign vid.pixel_tick   = pt_q;
  assign vid.frame_start  = fs_q;
endmodule

// File: tb/tb_vga_timing_generator.sv
// Random-reset bench for vga_timing_generator: CLK_DIV=4 and CLK_DIV=1 instances on a shrunken raster.
module tb_vga_timing_generator;
  localparam int HA = 20, HF = 3, HS = 5, HB = 4;
  localparam int VA = 12, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int NPOS = HT * VT;

  logic clk_in;
  logic reset;
  int   n;
  int   cyc;
  int   vectors;
  int   miscompares;
  int   last_fs [2];
  int   en_cnt  [2];
  bit   have_fs [2];

  vga_timing_if vid4 ();
  vga_timing_if vid1 ();

  vga_timing_generator #(
    .CLK_DIV(4), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) u_dut4 (
    .clk_in (clk_in),
    .reset  (reset),
    .vid    (vid4)
  );

  vga_timing_generator #(
    .CLK_DIV(1), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) u_dut1 (
    .clk_in (clk_in),
    .reset  (reset),
    .vid    (vid1)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s n=%0d got=%0d exp=%0d", tag, n, got, exp);
    end
  endtask

  // Raster position as a linear index: ticks since release, starting from the last pixel.
  function automatic int pos_at(input int cd, input int edges);
    return ((edges / cd) + NPOS - 1) % NPOS;
  endfunction

  function automatic logic hs_of(input int p);
    int x;
    x = p % HT;
    return !(x >= HA + HF && x < HA + HF + HS);
  endfunction

  function automatic logic vs_of(input int p);
    int y;
    y = p / HT;
    return !(y >= VA + VF && y < VA + VF + VS);
  endfunction

  task automatic check_dut(input string pfx, input int idx, input int cd,
                           input logic [9:0] row, input logic [9:0] line,
                           input logic en, input logic hs, input logic vs,
                           input logic pt, input logic fs);
    int   p;
    logic ept, ehs, evs;
    p   = pos_at(cd, n);
    ept = (n > 0) && (n % cd == 0);
`ifdef VGA_SYNC_DELAY_EN
    ehs = (n == 0) ? 1'b1 : hs_of(pos_at(cd, n - 1));
    evs = (n == 0) ? 1'b1 : vs_of(pos_at(cd, n - 1));
`else
    ehs = hs_of(p);
    evs = vs_of(p);
`endif
    chk({pfx, "row"},   32'(row),  32'(p % HT));
    chk({pfx, "line"},  32'(line), 32'(p / HT));
    chk({pfx, "en"},    32'(en),   32'((p % HT < HA) && (p / HT < VA)));
    chk({pfx, "hsync"}, 32'(hs),   32'(ehs));
    chk({pfx, "vsync"}, 32'(vs),   32'(evs));
    chk({pfx, "tick"},  32'(pt),   32'(ept));
    chk({pfx, "fs"},    32'(fs),   32'(ept && p == 0));
    // Frame-level properties independent of the per-cycle model.
    if (fs) begin
      if (have_fs[idx]) begin
        chk({pfx, "frame_clks"}, 32'(cyc - last_fs[idx]), 32'(NPOS * cd));
        chk({pfx, "frame_en"},   32'(en_cnt[idx]),        32'(HA * VA));
      end
      have_fs[idx] = 1'b1;
      last_fs[idx] = cyc;
      en_cnt[idx]  = 0;
    end
    if (pt && en) en_cnt[idx]++;
  endtask

  task automatic check_all();
    check_dut("d4.", 0, 4, vid4.current_row, vid4.current_line, vid4.enable,
              vid4.hsync, vid4.vsync, vid4.pixel_tick, vid4.frame_start);
    check_dut("d1.", 1, 1, vid1.current_row, vid1.current_line, vid1.enable,
              vid1.hsync, vid1.vsync, vid1.pixel_tick, vid1.frame_start);
  endtask

  task automatic step();
    @(posedge clk_in);
    if (!reset) n++;
    cyc++;
    @(negedge clk_in);
    check_all();
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) step();
  endtask

  task automatic release_reset();
    #1;
    reset = 1'b0;
  endtask

  // Assert reset between edges and confirm the outputs react before the next edge.
  task automatic mid_reset(input int hold);
    #($urandom_range(1, 3));
    reset      = 1'b1;
    n          = 0;
    have_fs[0] = 1'b0;
    have_fs[1] = 1'b0;
    #1;
    check_all();
    run(hold);
    release_reset();
  endtask

  initial begin
    reset       = 1'b1;
    n           = 0;
    cyc         = 0;
    vectors     = 0;
    miscompares = 0;
    have_fs     = '{default: 1'b0};
    en_cnt      = '{default: 0};
    last_fs     = '{default: 0};
    run(5);
    release_reset();
    run(NPOS * 4 * 3 + 20);
    for (int k = 0; k < 8; k++) begin
      run($urandom_range(50, 1500));
      mid_reset($urandom_range(1, 6));
    end
    run(NPOS * 4 + 40);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
